// File: rtl/vector_issue_sequencer_pkg.sv
// Shared vector execute-stage definitions: word width, lane opcodes, sequencer states.
package vector_pkg;

  localparam int WORD_W = 32;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Beat counter never collapses to zero width when a vector fits in one beat.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vector_issue_sequencer_if.sv
// Request, lane-drive and result signals between the execute stage and the sequencer.
interface vector_issue_sequencer_if #(
  parameter int ELEMS = 8,
  parameter int LANES = 4
);
  import vector_pkg::*;

  logic                      start_valid;
  logic                      start_ready;
  logic [2:0]                alu_op;
  logic                      vc_sub;
  logic [ELEMS*WORD_W-1:0]   vec_a;
  logic [ELEMS*WORD_W-1:0]   vec_b;
  logic [2:0]                lane_op;
  logic                      lane_vcsub;
  logic [LANES*WORD_W-1:0]   lane_a;
  logic [LANES*WORD_W-1:0]   lane_b;
  logic [LANES*WORD_W-1:0]   lane_out;
  logic [ELEMS*WORD_W-1:0]   result;
  logic                      result_valid;
  logic                      result_ready;
  logic                      busy;

  modport master (
    output start_valid, alu_op, vc_sub, vec_a, vec_b, lane_out, result_ready,
    input  start_ready, lane_op, lane_vcsub, lane_a, lane_b, result, result_valid, busy
  );

  modport slave (
    input  start_valid, alu_op, vc_sub, vec_a, vec_b, lane_out, result_ready,
    output start_ready, lane_op, lane_vcsub, lane_a, lane_b, result, result_valid, busy
  );

endinterface

// File: rtl/vector_issue_sequencer_slice_mux.sv
// Selects the LANES-wide slice of a packed vector that belongs to a given beat.
module vector_slice_mux
  import vector_pkg::*;
#(
  parameter int ELEMS  = 8,
  parameter int LANES  = 4,
  parameter int BEAT_W = 1
) (
  input  logic [ELEMS*WORD_W-1:0] i_vec,
  input  logic [BEAT_W-1:0]       i_beat,
  output logic [LANES*WORD_W-1:0] o_slice
);

  localparam int BEATS   = ELEMS / LANES;
  localparam int SLICE_W = LANES * WORD_W;

  always_comb begin
    o_slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (i_beat == BEAT_W'(b)) o_slice = i_vec[b*SLICE_W +: SLICE_W];
    end
  end

endmodule

// File: rtl/vector_issue_sequencer.sv
// Issues one latched vector op to LANES ALU lanes over ELEMS/LANES beats and assembles the result.
// IDLE | accepting a request   ISSUE | driving lanes, capturing lane_out   DONE | result_valid held
module vector_issue_sequencer
  import vector_pkg::*;
#(
  parameter int ELEMS = 8,
  parameter int LANES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_issue_sequencer_if.slave bus
);

  localparam int BEATS   = ELEMS / LANES;
  localparam int BEAT_W  = beat_w(BEATS);
  localparam int VEC_W   = ELEMS * WORD_W;
  localparam int SLICE_W = LANES * WORD_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  seq_state_t          r_state;
  seq_state_t          w_next;
  logic [BEAT_W-1:0]   r_beat;
  logic [2:0]          r_op;
  logic                r_vcsub;
  logic [VEC_W-1:0]    r_a;
  logic [VEC_W-1:0]    r_b;
  logic [VEC_W-1:0]    r_result;
  logic [SLICE_W-1:0]  w_slice_a;
  logic [SLICE_W-1:0]  w_slice_b;

  vector_slice_mux #(.ELEMS(ELEMS), .LANES(LANES), .BEAT_W(BEAT_W)) u_mux_a (
    .i_vec   (r_a),
    .i_beat  (r_beat),
    .o_slice (w_slice_a)
  );

  vector_slice_mux #(.ELEMS(ELEMS), .LANES(LANES), .BEAT_W(BEAT_W)) u_mux_b (
    .i_vec   (r_b),
    .i_beat  (r_beat),
    .o_slice (w_slice_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.start_ready  = 1'b0;
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    bus.lane_op      = OP_PASS;
    bus.lane_vcsub   = 1'b0;
    bus.lane_a       = '0;
    bus.lane_b       = '0;
    case (r_state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) w_next = ISSUE;
      end
      ISSUE: begin
        bus.busy       = 1'b1;
        bus.lane_op    = r_op;
        bus.lane_vcsub = r_vcsub;
        bus.lane_a     = w_slice_a;
        bus.lane_b     = w_slice_b;
        if (r_beat == LAST_BEAT) w_next = DONE;
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.result_valid = 1'b1;
        if (bus.result_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat   <= '0;
      r_op     <= OP_PASS;
      r_vcsub  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (r_state == IDLE && bus.start_valid) begin
      r_beat  <= '0;
      r_op    <= bus.alu_op;
      r_vcsub <= bus.vc_sub;
      r_a     <= bus.vec_a;
      r_b     <= bus.vec_b;
    end else if (r_state == ISSUE) begin
      for (int b = 0; b < BEATS; b++) begin
        if (r_beat == BEAT_W'(b)) r_result[b*SLICE_W +: SLICE_W] <= bus.lane_out;
      end
      // Explicit wrap keeps the counter correct when BEATS is not a power of two.
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  assign bus.result = r_result;

endmodule
